// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: arbitrates exceptions, mret and interrupts,
// drains the pipeline, pulses a commit to the CSR file, then hands fetch a redirect.
module trap_sequencer #(
   parameter int DRAIN_MAX = 64
) (
   input  logic        ctrl_clk,
   input  logic        ctrl_reset_n,
   input  logic        exc_valid,
   input  logic [3:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        mret_valid,
   input  logic [31:0] irq_pc,
   input  logic        csr_mie,
   input  logic [2:0]  csr_mxie,
   input  logic [2:0]  csr_mxip,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   input  logic        pipe_drained,
   output logic        pipe_hold,
   output logic        ctrl_trap,
   output logic        ctrl_mret,
   output logic [31:0] trap_pc,
   output logic [4:0]  trap_info,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        drain_timeout
);

   localparam int CW = $clog2(DRAIN_MAX) + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
   typedef enum logic [1:0] {KIND_EXC, KIND_IRQ, KIND_MRET} kind_t;

   state_t        state, state_next;
   kind_t         kind;
   logic [4:0]    cause;
   logic [31:0]   pc_lat;
   logic [CW-1:0] drain_cnt;
   logic [2:0]    irq_mask;
   logic          irq_take;
   logic [3:0]    irq_code;
   logic [31:0]   tvec_base;
   logic [31:0]   target;

   assign irq_mask = csr_mxie & csr_mxip;
   assign irq_take = csr_mie & (|irq_mask);

   // External beats software beats timer when several are pending together.
   always_comb begin
      irq_code = 4'd7;
      if (irq_mask[0]) begin
         irq_code = 4'd11;
      end else if (irq_mask[1]) begin
         irq_code = 4'd3;
      end
   end

   always_comb begin
      tvec_base = {csr_mtvec[31:2], 2'b00};
      target    = tvec_base;
      if (kind == KIND_MRET) begin
         target = csr_mepc;
      end else if (csr_mtvec[1:0] == 2'b01 && kind == KIND_IRQ) begin
         target = tvec_base + {26'd0, cause[3:0], 2'b00};
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:     if (exc_valid || mret_valid || irq_take) state_next = DRAIN;
         DRAIN:    if (pipe_drained) state_next = COMMIT;
         COMMIT:   state_next = REDIRECT;
         REDIRECT: if (redirect_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state       <= IDLE;
         pipe_hold   <= 1'b0;
         kind        <= KIND_EXC;
         cause       <= '0;
         pc_lat      <= '0;
         redirect_pc <= '0;
      end else begin
         state     <= state_next;
         pipe_hold <= (state_next != IDLE);
         if (state == IDLE) begin
            if (exc_valid) begin
               kind   <= KIND_EXC;
               cause  <= {1'b0, exc_code};
               pc_lat <= exc_pc;
            end else if (mret_valid) begin
               kind <= KIND_MRET;
            end else if (irq_take) begin
               kind   <= KIND_IRQ;
               cause  <= {1'b1, irq_code};
               pc_lat <= irq_pc;
            end
         end
         if (state == COMMIT) begin
            redirect_pc <= target;
         end
      end
   end

   // Counter saturates at DRAIN_MAX; the timeout flag only clears on reset.
   always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         drain_cnt     <= '0;
         drain_timeout <= 1'b0;
      end else if (state == DRAIN) begin
         if (pipe_drained) begin
            drain_cnt <= '0;
         end else if (drain_cnt < CW'(DRAIN_MAX)) begin
            drain_cnt <= drain_cnt + CW'(1);
            if (drain_cnt == CW'(DRAIN_MAX - 1)) begin
               drain_timeout <= 1'b1;
            end
         end
      end
   end

   assign ctrl_trap      = (state == COMMIT);
   assign ctrl_mret      = (state == COMMIT) && (kind == KIND_MRET);
   assign trap_pc        = (ctrl_trap && !ctrl_mret) ? pc_lat : 32'd0;
   assign trap_info      = (ctrl_trap && !ctrl_mret) ? cause : 5'd0;
   assign redirect_valid = (state == REDIRECT);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: stimulus pushes expected commits/redirects
// into queues that a negedge monitor pops whenever the DUT presents them.
module tb_trap_sequencer;

   typedef struct packed {
      logic        mret;
      logic [31:0] pc;
      logic [4:0]  info;
   } commit_t;

   logic        ctrl_clk = 1'b0;
   logic        ctrl_reset_n;
   logic        exc_valid, mret_valid, csr_mie, pipe_drained, redirect_ready;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc, irq_pc, csr_mtvec, csr_mepc;
   logic [2:0]  csr_mxie, csr_mxip;
   logic        pipe_hold, ctrl_trap, ctrl_mret, redirect_valid, drain_timeout;
   logic [31:0] trap_pc, redirect_pc;
   logic [4:0]  trap_info;

   commit_t     commit_q[$];
   logic [31:0] redir_q[$];
   int          checks = 0;
   int          errors = 0;

   trap_sequencer #(.DRAIN_MAX(4)) dut (
      .ctrl_clk(ctrl_clk), .ctrl_reset_n(ctrl_reset_n),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .mret_valid(mret_valid), .irq_pc(irq_pc),
      .csr_mie(csr_mie), .csr_mxie(csr_mxie), .csr_mxip(csr_mxip),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .pipe_drained(pipe_drained), .pipe_hold(pipe_hold),
      .ctrl_trap(ctrl_trap), .ctrl_mret(ctrl_mret),
      .trap_pc(trap_pc), .trap_info(trap_info),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .drain_timeout(drain_timeout)
   );

   always #5 ctrl_clk = ~ctrl_clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ctrl_clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge ctrl_clk);
         if (!pipe_hold) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL %s: got pipe_hold stuck high expected return to idle within 30 cycles", name);
      end
   endtask

   task automatic apply_stimulus(input logic exc, input logic [3:0] code, input logic [31:0] epc,
                                 input logic mret, input logic mie, input logic [2:0] mxie,
                                 input logic [2:0] mxip, input logic [31:0] ipc);
      exc_valid  = exc;
      exc_code   = code;
      exc_pc     = epc;
      mret_valid = mret;
      csr_mie    = mie;
      csr_mxie   = mxie;
      csr_mxip   = mxip;
      irq_pc     = ipc;
   endtask

   task automatic clear_requests();
      apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0);
   endtask

   // Monitor: every commit pulse and every redirect handshake must match the queue head.
   initial begin
      commit_t act_c, exp_c;
      forever begin
         @(negedge ctrl_clk);
         if (ctrl_reset_n === 1'b1) begin
            if (ctrl_trap) begin
               check_output("commit_excludes_redirect", {63'd0, redirect_valid}, 64'd0);
               checks++;
               if (commit_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_commit: got ctrl_trap=1 pc=%h info=%h expected no commit",
                           trap_pc, trap_info);
               end else begin
                  exp_c = commit_q.pop_front();
                  act_c = '{mret: ctrl_mret, pc: trap_pc, info: trap_info};
                  checks--;
                  check_output("commit_mret_pc_info", 64'(act_c), 64'(exp_c));
               end
            end
            if (redirect_valid && redirect_ready) begin
               checks++;
               if (redir_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_redirect: got redirect_pc=%h expected no redirect", redirect_pc);
               end else begin
                  checks--;
                  check_output("redirect_pc", 64'(redirect_pc), 64'(redir_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ctrl_reset_n   = 1'b0;
      clear_requests();
      csr_mtvec      = 32'h0000_8000;
      csr_mepc       = 32'd0;
      pipe_drained   = 1'b1;
      redirect_ready = 1'b1;
      repeat (3) @(negedge ctrl_clk);
      check_output("reset_outputs",
                   {pipe_hold, ctrl_trap, ctrl_mret, redirect_valid, drain_timeout, trap_pc, trap_info},
                   64'd0);
      ctrl_reset_n = 1'b1;
      @(negedge ctrl_clk);
      check_output("idle_after_reset", {62'd0, pipe_hold, redirect_valid}, 64'd0);

      // Exception, direct mtvec
      tick();
      apply_stimulus(1'b1, 4'd2, 32'h100, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0);
      commit_q.push_back('{mret: 1'b0, pc: 32'h100, info: 5'h02});
      redir_q.push_back(32'h8000);
      tick();
      clear_requests();
      wait_idle("exc_direct_idle");

      // Vectored interrupt, software wins; pending drops right after acceptance
      tick();
      csr_mtvec = 32'h0000_8001;
      apply_stimulus(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 3'b111, 3'b110, 32'h240);
      commit_q.push_back('{mret: 1'b0, pc: 32'h240, info: 5'h13});
      redir_q.push_back(32'h800C);
      tick();
      clear_requests();
      wait_idle("irq_vectored_idle");

      // mret: commit lands in the second cycle after the request cycle
      tick();
      csr_mepc = 32'h1234;
      apply_stimulus(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 3'b000, 3'b000, 32'd0);
      commit_q.push_back('{mret: 1'b1, pc: 32'd0, info: 5'd0});
      redir_q.push_back(32'h1234);
      tick();
      clear_requests();
      @(negedge ctrl_clk);
      check_output("mret_no_early_commit", {63'd0, ctrl_trap}, 64'd0);
      @(negedge ctrl_clk);
      check_output("mret_commit_strobes", {62'd0, ctrl_trap, ctrl_mret}, 64'd3);
      wait_idle("mret_idle");

      // Simultaneous requests with a slow drain; exception ignores vectoring
      tick();
      csr_mtvec    = 32'h0000_9001;
      pipe_drained = 1'b0;
      apply_stimulus(1'b1, 4'd5, 32'h300, 1'b1, 1'b1, 3'b001, 3'b001, 32'h500);
      commit_q.push_back('{mret: 1'b0, pc: 32'h300, info: 5'h05});
      redir_q.push_back(32'h9000);
      tick();
      clear_requests();
      for (int i = 0; i < 5; i++) begin
         @(negedge ctrl_clk);
         check_output("drain_hold_no_commit", {62'd0, pipe_hold, ctrl_trap}, 64'd2);
      end
      tick();
      pipe_drained = 1'b1;
      @(negedge ctrl_clk);
      check_output("commit_waits_drained_edge", {63'd0, ctrl_trap}, 64'd0);
      @(negedge ctrl_clk);
      check_output("commit_after_drained", {63'd0, ctrl_trap}, 64'd1);
      wait_idle("simultaneous_idle");

      // Async reset mid-drain aborts the request without a commit
      tick();
      csr_mtvec    = 32'h0000_8000;
      pipe_drained = 1'b0;
      apply_stimulus(1'b1, 4'd7, 32'h700, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0);
      tick();
      clear_requests();
      @(negedge ctrl_clk);
      check_output("hold_before_reset", {63'd0, pipe_hold}, 64'd1);
      #2;
      ctrl_reset_n = 1'b0;
      #1;
      check_output("async_reset_outputs",
                   {pipe_hold, ctrl_trap, ctrl_mret, redirect_valid, drain_timeout, trap_pc, trap_info},
                   64'd0);
      pipe_drained = 1'b1;
      @(negedge ctrl_clk);
      @(negedge ctrl_clk);
      ctrl_reset_n = 1'b1;
      repeat (6) @(negedge ctrl_clk);
      check_output("no_hold_after_abort", {63'd0, pipe_hold}, 64'd0);

      // Drain timeout at DRAIN_MAX=4, then redirect backpressure
      tick();
      pipe_drained   = 1'b0;
      redirect_ready = 1'b0;
      apply_stimulus(1'b1, 4'd1, 32'h400, 1'b0, 1'b0, 3'b000, 3'b000, 32'd0);
      commit_q.push_back('{mret: 1'b0, pc: 32'h400, info: 5'h01});
      redir_q.push_back(32'h8000);
      tick();
      clear_requests();
      for (int k = 1; k <= 10; k++) begin
         @(negedge ctrl_clk);
         check_output($sformatf("drain_timeout_cycle%0d", k), {63'd0, drain_timeout}, (k >= 5) ? 64'd1 : 64'd0);
      end
      tick();
      pipe_drained = 1'b1;
      @(negedge ctrl_clk);
      @(negedge ctrl_clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge ctrl_clk);
         check_output("redirect_held", {31'd0, redirect_valid, redirect_pc}, {31'd0, 1'b1, 32'h8000});
      end
      tick();
      redirect_ready = 1'b1;
      wait_idle("timeout_idle");
      check_output("timeout_sticky", {63'd0, drain_timeout}, 64'd1);

      repeat (2) @(negedge ctrl_clk);
      check_output("queues_drained", 64'(commit_q.size() + redir_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
